// File: rtl/condicionador_entradas_pkg.sv
// Shared definitions for the input-conditioning stage: FSM state codes
// (shown directly on a hexa7seg display) and the default debounce length.
package condicionador_entradas_pkg;

  // Jogada FSM state codes; 4 bits wide so they map straight onto db_estado
  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    PRESSIONADO = 4'd1
  } estado_t;

  // 1 ms at 50 MHz
  localparam int DEBOUNCE_CICLOS_PADRAO = 50000;

endpackage

// File: rtl/condicionador_entradas_debouncer.sv
// Single-bit conditioner: two-flop synchroniser followed by a counter that
// accepts a new level only after it has persisted DEBOUNCE_CICLOS clocks.
module debouncer #(
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic bruto,
  output logic estavel
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CICLOS - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser; only s2 is ever read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bruto;
      s2 <= s1;
    end
  end

  // Accept s2 once it has differed from the stable level for DEBOUNCE_CICLOS clocks
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      estavel <= 1'b0;
    end else if (s2 == estavel) begin
      cnt <= '0;
    end else if (cnt == LIMITE) begin
      estavel <= s2;
      cnt     <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/condicionador_entradas.sv
// Input conditioning ahead of the game top level: debounces the start button
// and the switches, emits a one-cycle iniciar pulse on each press, and a
// one-cycle jogada pulse with the switch code captured when the switches
// leave all-zero. Every output comes from registers, never from a raw input.
module condicionador_entradas
  import condicionador_entradas_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int N_CHAVES        = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar_bruto,
  input  logic [N_CHAVES-1:0] chaves_bruto,
  output logic                iniciar_pulso,
  output logic [N_CHAVES-1:0] chaves_estav,
  output logic                jogada,
  output logic [N_CHAVES-1:0] chaves_jogada,
  output logic                db_multiplas,
  output logic [3:0]          db_estado
);

  logic    estavel_ini;
  logic    estavel_ini_d;
  logic    captura;
  estado_t estado;
  estado_t proximo;

  debouncer #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_db_iniciar (
    .clock   (clock),
    .reset   (reset),
    .bruto   (iniciar_bruto),
    .estavel (estavel_ini)
  );

  for (genvar i = 0; i < N_CHAVES; i++) begin : g_chaves
    debouncer #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_db_chave (
      .clock   (clock),
      .reset   (reset),
      .bruto   (chaves_bruto[i]),
      .estavel (chaves_estav[i])
    );
  end

  // Delayed copy of the debounced button for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estavel_ini_d <= 1'b0;
    else       estavel_ini_d <= estavel_ini;
  end

  assign iniciar_pulso = estavel_ini & ~estavel_ini_d;

  // Jogada FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // Jogada FSM next state: arm on any switch, rearm only when all are released
  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:      if (chaves_estav != '0) proximo = PRESSIONADO;
      PRESSIONADO: if (chaves_estav == '0) proximo = OCIOSO;
      default:     proximo = OCIOSO;
    endcase
  end

  // Jogada FSM outputs: pulse and capture strobe only on the OCIOSO exit cycle
  always_comb begin
    captura = 1'b0;
    if (estado == OCIOSO && chaves_estav != '0) captura = 1'b1;
  end

  assign jogada    = captura;
  assign db_estado = estado;

  // Hold the switch code seen on the jogada cycle until the next jogada
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        chaves_jogada <= '0;
    else if (captura) chaves_jogada <= chaves_estav;
  end

  // More than one bit set: clearing the lowest set bit leaves something
  assign db_multiplas = (chaves_jogada & (chaves_jogada - N_CHAVES'(1))) != '0;

endmodule

// File: tb/tb_condicionador_entradas.sv
// Directed bench for condicionador_entradas with DEBOUNCE_CICLOS=4, N_CHAVES=4.
module tb_condicionador_entradas;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar_bruto = 1'b0;
  logic [3:0] chaves_bruto = 4'b0000;
  logic       iniciar_pulso;
  logic [3:0] chaves_estav;
  logic       jogada;
  logic [3:0] chaves_jogada;
  logic       db_multiplas;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_err    = 0;
  int n_ini, n_jog, p_ini, p_jog;

  condicionador_entradas #(.DEBOUNCE_CICLOS(4), .N_CHAVES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar_bruto (iniciar_bruto),
    .chaves_bruto  (chaves_bruto),
    .iniciar_pulso (iniciar_pulso),
    .chaves_estav  (chaves_estav),
    .jogada        (jogada),
    .chaves_jogada (chaves_jogada),
    .db_multiplas  (db_multiplas),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, esp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Run n edges; count pulses and note the edge index (1-based) of the first one
  task automatic rodar(input int n, output int ni, output int nj, output int pi, output int pj);
    ni = 0; nj = 0; pi = 0; pj = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (iniciar_pulso) begin ni++; if (pi == 0) pi = k; end
      if (jogada)        begin nj++; if (pj == 0) pj = k; end
    end
  endtask

  task automatic tudo_zero(input string tag);
    verificar({tag, "_outs"},
              {iniciar_pulso, chaves_estav, jogada, chaves_jogada, db_multiplas, db_estado}, 32'h0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    tudo_zero("reset");
    reset = 1'b0;
    tick();
    tudo_zero("pos_reset");

    // 1. Clean press held 20 cycles
    iniciar_bruto = 1'b1;
    rodar(20, n_ini, n_jog, p_ini, p_jog);
    verificar("t1_n_ini", n_ini, 1);
    verificar("t1_edge_ini", p_ini, 6);
    verificar("t1_n_jog", n_jog, 0);
    verificar("t1_estav", chaves_estav, 4'h0);
    verificar("t1_capt", chaves_jogada, 4'h0);

    // 2. Release, short pulse, bounce
    iniciar_bruto = 1'b0;
    rodar(10, n_ini, n_jog, p_ini, p_jog);
    verificar("t2_release", n_ini, 0);
    iniciar_bruto = 1'b1; tick(); tick(); tick();
    iniciar_bruto = 1'b0;
    rodar(12, n_ini, n_jog, p_ini, p_jog);
    verificar("t2_short", n_ini, 0);
    iniciar_bruto = 1'b1; tick();
    iniciar_bruto = 1'b0; tick();
    iniciar_bruto = 1'b1; tick();
    iniciar_bruto = 1'b0;
    rodar(12, n_ini, n_jog, p_ini, p_jog);
    verificar("t2_bounce", n_ini, 0);

    // 3. Single switch press and release
    chaves_bruto = 4'b0100;
    rodar(6, n_ini, n_jog, p_ini, p_jog);
    verificar("t3_n_jog", n_jog, 1);
    verificar("t3_edge_jog", p_jog, 6);
    verificar("t3_estado_ocioso", db_estado, 4'd0);
    tick();
    verificar("t3_jog_one_cycle", jogada, 1'b0);
    verificar("t3_estado_press", db_estado, 4'd1);
    verificar("t3_capt", chaves_jogada, 4'b0100);
    verificar("t3_mult", db_multiplas, 1'b0);
    rodar(3, n_ini, n_jog, p_ini, p_jog);
    verificar("t3_held", n_jog, 0);
    chaves_bruto = 4'b0000;
    rodar(10, n_ini, n_jog, p_ini, p_jog);
    verificar("t3_no_release_pulse", n_jog, 0);
    verificar("t3_estado_back", db_estado, 4'd0);
    verificar("t3_capt_hold", chaves_jogada, 4'b0100);

    // 4. Simultaneous bits, later bit ignored
    chaves_bruto = 4'b0011;
    rodar(6, n_ini, n_jog, p_ini, p_jog);
    verificar("t4_edge_jog", p_jog, 6);
    verificar("t4_n_jog", n_jog, 1);
    tick();
    verificar("t4_capt", chaves_jogada, 4'b0011);
    verificar("t4_mult", db_multiplas, 1'b1);
    chaves_bruto = 4'b1011;
    rodar(10, n_ini, n_jog, p_ini, p_jog);
    verificar("t4_no_new_jog", n_jog, 0);
    verificar("t4_capt_kept", chaves_jogada, 4'b0011);
    verificar("t4_estav", chaves_estav, 4'b1011);
    chaves_bruto = 4'b0000;
    rodar(10, n_ini, n_jog, p_ini, p_jog);
    verificar("t4_estado_back", db_estado, 4'd0);

    // 5. Reset in mid-debounce with inputs held
    iniciar_bruto = 1'b1;
    chaves_bruto  = 4'b1000;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    #1;
    tudo_zero("t5_async");
    tick();
    tudo_zero("t5_in_reset");
    reset = 1'b0;
    rodar(6, n_ini, n_jog, p_ini, p_jog);
    verificar("t5_edge_ini", p_ini, 6);
    verificar("t5_edge_jog", p_jog, 6);
    verificar("t5_n", n_ini + n_jog, 2);
    tick();
    verificar("t5_capt", chaves_jogada, 4'b1000);
    iniciar_bruto = 1'b0;
    chaves_bruto  = 4'b0000;
    rodar(10, n_ini, n_jog, p_ini, p_jog);
    verificar("t5_idle", db_estado, 4'd0);

    // 6. Staggered bits: only the first is captured
    chaves_bruto = 4'b0001;
    tick(); tick();
    chaves_bruto = 4'b0011;
    rodar(4, n_ini, n_jog, p_ini, p_jog);
    verificar("t6_edge_jog", p_jog, 4);
    tick();
    verificar("t6_capt", chaves_jogada, 4'b0001);
    verificar("t6_mult", db_multiplas, 1'b0);
    rodar(5, n_ini, n_jog, p_ini, p_jog);
    verificar("t6_no_new_jog", n_jog, 0);
    verificar("t6_estav", chaves_estav, 4'b0011);
    chaves_bruto = 4'b0000;
    rodar(10, n_ini, n_jog, p_ini, p_jog);
    verificar("t6_estado_back", db_estado, 4'd0);
    verificar("t6_capt_hold", chaves_jogada, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
